edulent_program_memory: RTL
===========================

# edulent_program_memory

256 x 8 program/data memory that responds to the Edulent data path's memory interface: combinational read, single-cycle synchronous write. It also contains a byte-stream program loader with a valid/ready handshake that fills memory from address 0 while holding the CPU in reset, then releases it. It sits between the data path and the board-level host link (UART or testbench).

## Interface
Parameters:
- `ADDR_W`, 8: address width. Depth is 2**ADDR_W.
- `DATA_W`, 8: data width.

Ports:
- `i_clk`  in  1  single clock; all state changes on the rising edge.
- `i_rstn`  in  1  reset, synchronous and active-low.
- `i_mem_addr`  in  ADDR_W  CPU address (data path MA).
- `i_mem_write_enable`  in  1  CPU write strobe, one cycle per write.
- `i_mem_data_write`  in  DATA_W  CPU write data.
- `o_mem_data_read`  out  DATA_W  read data, combinational from `i_mem_addr`.
- `i_load_start`  in  1  pulse: begin a load.
- `i_load_len`  in  ADDR_W+1  number of bytes to load (0..256); sampled when `i_load_start` is accepted.
- `i_load_valid`  in  1  loader byte valid.
- `i_load_data`  in  DATA_W  loader byte.
- `o_load_ready`  out  1  loader byte accepted when `valid && ready`.
- `o_load_done`  out  1  one-cycle pulse when the load completes.
- `o_cpu_rstn`  out  1  registered active-low reset to the CPU; low outside RUN.

## Operation
- FSM states: IDLE, CLEAR (only with the macro), LOAD, RUN.
- After reset: state IDLE, `o_cpu_rstn`=0, `o_load_ready`=0, `o_load_done`=0, pointer and count = 0. Memory contents are not reset.
- IDLE or RUN + `i_load_start`:
  - Latch `len`, set pointer to 0.
  - Go to CLEAR if the macro is compiled in, else go to LOAD.
  - `o_cpu_rstn` drops on the next edge.
- LOAD:
  - `o_load_ready`=1.
  - Each handshake writes `mem[ptr] <= i_load_data`, then `ptr++` and `count++`.
  - When `count` reaches `len`, go to RUN.
  - With `len`=0, go to RUN directly from the start, with no writes.
- Entering RUN: `o_load_done` high for exactly one cycle; `o_cpu_rstn`=1 from that same cycle.
- `i_load_start` during CLEAR or LOAD is ignored.
- Write-port ownership:
  - RUN: the CPU owns the write port. `i_mem_write_enable` writes `i_mem_data_write` to `mem[i_mem_addr]` on that edge.
  - Any other state: the loader owns the write port and CPU writes are dropped.
- Read path: `o_mem_data_read = mem[i_mem_addr]` in every state, with no latency. The data path latches MD one cycle after MA updates, so read data must not be registered.
- Read-during-write to the same address returns the old data until the edge.
- The pointer is ADDR_W bits; `len`=256 fills every location with no wrap beyond that.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency: 1 edge. Data is visible on reads in the cycle after the write edge.
- Loader throughput: 1 byte per cycle while `i_load_valid` is held.
- Last byte accepted at edge N: state is RUN and `o_load_done`=1 and `o_cpu_rstn`=1 after edge N+1.
- Start at edge S: `o_load_ready`=1 after edge S (LOAD), or after edge S+2**ADDR_W (CLEAR).
- `i_rstn` low during any state: IDLE on the next edge, and any partial load is abandoned.

## Configuration
- `EDULENT_MEM_CLEAR_EN`
  - Defined: on start, CLEAR writes 0 to every location, one per cycle, in 2**ADDR_W cycles with `o_load_ready`=0. It then enters LOAD, or RUN if `len`=0.
  - Undefined: no CLEAR state, and locations beyond `len` keep their prior contents.

## Structure
- Shared package `edulent_pkg`:
  - state enum `mem_state_t` (IDLE, CLEAR, LOAD, RUN)
  - `EDULENT_ADDR_W`=8
  - `EDULENT_DATA_W`=8
- One sub-module, `edulent_ram`: storage array with a combinational read port and one synchronous write port (we, addr, data).
- The top level holds the FSM, the counters and the write-port mux.

## Test plan
- Reset, start with `len`=3, bytes 0x11, 0xA5, 0x3C back-to-back. Expect addr 0/1/2 to read 0x11/0xA5/0x3C; one `o_load_done` pulse; `o_cpu_rstn` rises the cycle after the third handshake.
- Load `len`=4 with `i_load_valid` toggling every other cycle. Expect only the 4 handshaked bytes at addr 0..3; done 8 cycles after start.
- RUN, CPU write 0x5A to 0x80 with `we` for one cycle. Expect `o_mem_data_read`=0x5A at addr 0x80 the next cycle; combinational read of 0x00 shows the loaded byte.
- IDLE, CPU write 0x77 to 0x10. Expect addr 0x10 unchanged. `len`=0 start: expect done on the next edge and no memory writes.
- Restart load in RUN (`len`=1, byte 0x99). Expect `o_cpu_rstn`=0 the next cycle and addr 0 = 0x99.
- With `EDULENT_MEM_CLEAR_EN`, preload 0xFF=0xEE, start `len`=1. Expect `ready` low for 256 cycles, addr 0xFF reads 0x00 afterwards, addr 0 holds the loaded byte.

Source files
------------

// File: rtl/edulent_pkg.sv
// Shared types and default widths for the Edulent program memory slice.
package edulent_pkg;

    localparam int EDULENT_ADDR_W = 8;
    localparam int EDULENT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } mem_state_t;

endpackage

// File: rtl/edulent_ram.sv
// Storage array: combinational read port, one synchronous write port.
module edulent_ram
    import edulent_pkg::*;
#(
    parameter int ADDR_W = EDULENT_ADDR_W,
    parameter int DATA_W = EDULENT_DATA_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Unregistered on purpose: the data path latches MD one cycle after MA.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/edulent_program_memory.sv
// Edulent program memory with byte-stream loader that holds the CPU in reset while loading.
// Optional EDULENT_MEM_CLEAR_EN zeroes the whole array before each load.
module edulent_program_memory
    import edulent_pkg::*;
#(
    parameter int ADDR_W = EDULENT_ADDR_W,
    parameter int DATA_W = EDULENT_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic              i_mem_write_enable,
    input  logic [DATA_W-1:0] i_mem_data_write,
    output logic [DATA_W-1:0] o_mem_data_read,
    input  logic              i_load_start,
    input  logic [ADDR_W:0]   i_load_len,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    output logic              o_load_ready,
    output logic              o_load_done,
    output logic              o_cpu_rstn
);

    mem_state_t        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic [ADDR_W:0]   len_q;
    logic              ready_q;
    logic              done_q;
    logic              cpu_rstn_q;
    logic              handshake;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;

    assign ptr_d     = ptr_q + 1'b1;
    assign count_d   = count_q + 1'b1;
    assign handshake = (state_q == LOAD) && ready_q && i_load_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            len_q      <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            cpu_rstn_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, RUN: begin
                    if (i_load_start) begin
                        len_q   <= i_load_len;
                        ptr_q   <= '0;
                        count_q <= '0;
`ifdef EDULENT_MEM_CLEAR_EN
                        state_q    <= CLEAR;
                        ready_q    <= 1'b0;
                        cpu_rstn_q <= 1'b0;
`else
                        if (i_load_len == '0) begin
                            state_q    <= RUN;
                            done_q     <= 1'b1;
                            cpu_rstn_q <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            ready_q    <= 1'b1;
                            cpu_rstn_q <= 1'b0;
                        end
`endif
                    end
                end
`ifdef EDULENT_MEM_CLEAR_EN
                CLEAR: begin
                    // ptr wraps back to 0 on the last clear write, ready for LOAD.
                    ptr_q <= ptr_d;
                    if (ptr_q == '1) begin
                        if (len_q == '0) begin
                            state_q    <= RUN;
                            done_q     <= 1'b1;
                            cpu_rstn_q <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                            ready_q <= 1'b1;
                        end
                    end
                end
`endif
                LOAD: begin
                    if (count_q == len_q) begin
                        state_q    <= RUN;
                        done_q     <= 1'b1;
                        cpu_rstn_q <= 1'b1;
                        ready_q    <= 1'b0;
                    end else if (handshake) begin
                        ptr_q   <= ptr_d;
                        count_q <= count_d;
                        // Drop ready with the last byte so no extra byte is accepted.
                        if (count_d == len_q) begin
                            ready_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Write-port ownership: CPU in RUN, loader otherwise; nothing is written during reset.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = i_mem_addr;
        ram_data = i_mem_data_write;
        if (i_rstn) begin
            case (state_q)
                RUN: begin
                    ram_we = i_mem_write_enable;
                end
                LOAD: begin
                    ram_we   = handshake;
                    ram_addr = ptr_q;
                    ram_data = i_load_data;
                end
`ifdef EDULENT_MEM_CLEAR_EN
                CLEAR: begin
                    ram_we   = 1'b1;
                    ram_addr = ptr_q;
                    ram_data = '0;
                end
`endif
                default: begin
                    ram_we = 1'b0;
                end
            endcase
        end
    end

    edulent_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (i_clk),
        .we_i    (ram_we),
        .waddr_i (ram_addr),
        .wdata_i (ram_data),
        .raddr_i (i_mem_addr),
        .rdata_o (o_mem_data_read)
    );

    assign o_load_ready = ready_q;
    assign o_load_done  = done_q;
    assign o_cpu_rstn   = cpu_rstn_q;

endmodule
